// File: rtl/vec_mem_pkg.sv
// Shared types and widths for the vector data-memory arbiter.
package vec_mem_pkg;

    localparam int VEC_DW = 128;
    localparam int VEC_AW = 16;

    // Arbiter control states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Owner of an issued memory read, used to route the returned data.
    typedef enum logic [0:0] {
        OWN_P = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating wait counter for the burst reader. sat is high once the reader
// has waited MAX_WAIT cycles, so that it is forced in ahead of the pipeline.
module arb_starve_counter #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = ($clog2(MAX_WAIT + 1) > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WAIT);

    logic [CW-1:0] cnt_r;

    // Count waiting cycles; a grant clears the count, and it holds at MAX_WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && (cnt_r != MAX_C)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat = (cnt_r == MAX_C);

endmodule

// File: rtl/vector_mem_arbiter.sv
// Arbiter for the single vector data-memory port, shared between the pipeline
// memory stage (priority) and the image-burst reader. The reader is forced in
// after MAX_WAIT cycles of waiting and then owns the port for BURST_LEN reads.
// Optional build macro: ARB_PERF_CNT_EN enables the stall_cnt/burst_cnt
// performance counters; without it both outputs are tied to zero.
module vector_mem_arbiter
    import vec_mem_pkg::*;
#(
    parameter int DW        = VEC_DW,
    parameter int AW        = VEC_AW,
    parameter int BURST_LEN = 4,
    parameter int MAX_WAIT  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic          p_stall,
    output logic [DW-1:0] p_rdata,
    output logic          p_rvalid,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    output logic          d_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   burst_cnt
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    arb_state_t    state_r;
    arb_state_t    state_nxt_s;
    logic [AW-1:0] base_r;
    logic [BW-1:0] beat_r;
    logic [BW-1:0] beat_nxt_s;

    logic          starve_sat_s;
    logic          d_win_s;
    logic          p_win_s;
    owner_t        issue_own_s;
    logic          issue_last_s;

    logic          rd_pend_r;
    owner_t        rd_own_r;
    logic          rd_last_r;

    // Arbitration and memory-port drive; beat 0 of a burst issues in the grant cycle.
    always_comb begin
        state_nxt_s  = state_r;
        beat_nxt_s   = beat_r;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = {AW{1'b0}};
        mem_wdata    = {DW{1'b0}};
        d_win_s      = 1'b0;
        p_win_s      = 1'b0;
        issue_own_s  = OWN_P;
        issue_last_s = 1'b0;
        if (rst) begin
            state_nxt_s = IDLE;
            beat_nxt_s  = {BW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (d_req && starve_sat_s) begin
                        d_win_s = 1'b1;
                    end else if (p_req) begin
                        p_win_s = 1'b1;
                    end else if (d_req) begin
                        d_win_s = 1'b1;
                    end else begin
                        d_win_s = 1'b0;
                    end
                    if (d_win_s) begin
                        mem_en      = 1'b1;
                        mem_addr    = d_addr;
                        issue_own_s = OWN_D;
                        if (BURST_LEN > 1) begin
                            state_nxt_s  = BURST;
                            beat_nxt_s   = BW'(1);
                            issue_last_s = 1'b0;
                        end else begin
                            issue_last_s = 1'b1;
                        end
                    end else if (p_win_s) begin
                        mem_en    = 1'b1;
                        mem_we    = p_we;
                        mem_addr  = p_addr;
                        mem_wdata = p_wdata;
                    end else begin
                        mem_en = 1'b0;
                    end
                end
                BURST: begin
                    mem_en      = 1'b1;
                    mem_addr    = base_r + AW'(beat_r);
                    issue_own_s = OWN_D;
                    if (beat_r == LAST_BEAT) begin
                        issue_last_s = 1'b1;
                        state_nxt_s  = IDLE;
                        beat_nxt_s   = {BW{1'b0}};
                    end else begin
                        beat_nxt_s = beat_r + BW'(1);
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    beat_nxt_s  = {BW{1'b0}};
                end
            endcase
        end
    end

    assign d_gnt   = d_win_s;
    assign p_stall = p_req & ~p_win_s;

    // State, beat index and captured burst base address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            beat_r  <= {BW{1'b0}};
            base_r  <= {AW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            beat_r  <= beat_nxt_s;
            if (d_win_s) begin
                base_r <= d_addr;
            end else begin
                base_r <= base_r;
            end
        end
    end

    // Read-return tag: which requester gets next cycle's mem_rdata, and whether it ends a burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_r <= 1'b0;
            rd_own_r  <= OWN_P;
            rd_last_r <= 1'b0;
        end else begin
            rd_pend_r <= mem_en & ~mem_we;
            rd_own_r  <= issue_own_s;
            rd_last_r <= issue_last_s;
        end
    end

    assign p_rvalid = rd_pend_r & (rd_own_r == OWN_P);
    assign d_rvalid = rd_pend_r & (rd_own_r == OWN_D);
    assign d_done   = d_rvalid & rd_last_r;
    assign p_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

    // The reader waits whenever it requests without being granted this cycle.
    arb_starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (d_req & ~d_win_s),
        .clr (d_win_s),
        .sat (starve_sat_s)
    );

`ifdef ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] burst_cnt_r;

    // Free-running wrap-around counters of pipeline stall cycles and reader grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
            burst_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= stall_cnt_r + {31'd0, p_stall};
            burst_cnt_r <= burst_cnt_r + {31'd0, d_win_s};
        end
    end

    assign stall_cnt = stall_cnt_r;
    assign burst_cnt = burst_cnt_r;
`else
    assign stall_cnt = 32'd0;
    assign burst_cnt = 32'd0;
`endif

endmodule
